pixel_capture: RTL and testbench

PIXEL_CAPTURE -- requirements
Module: pixel_capture

---
 rtl/pixel_capture.sv | 186 ++++++++++++++++++
 tb/tb_pixel_capture.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_capture.sv
// Captures RGB565 pixels from an 8-bit parallel camera port into linear frame-buffer strobes.
// Camera signals are oversampled on CLK; PCLK is treated as data, so CLK must run at >= 4x PCLK.
module pixel_capture #(
    parameter int H_PIXELS = 640,
    parameter int V_PIXELS = 480,
    parameter int ADDR_W   = 19
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic              VSYNC,
    input  logic              HREF,
    input  logic              PCLK,
    input  logic [7:0]        D,
    output logic [15:0]       PIXEL_DATA,
    output logic              PIXEL_VALID,
    output logic [9:0]        PIXEL_COL,
    output logic [ADDR_W-1:0] PIXEL_ADDR,
    output logic              FRAME_DONE,
    output logic              LINE_ERR
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    localparam logic [9:0]        H_LIM    = 10'(H_PIXELS);
    localparam logic [9:0]        V_LIM    = 10'(V_PIXELS);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    // Control bit order in the synchronizer: [2] VSYNC, [1] HREF, [0] PCLK
    logic [2:0]        ctl_meta_r;
    logic [2:0]        ctl_sync_r;
    logic [2:0]        ctl_dly_r;
    logic [7:0]        d_meta_r;
    logic [7:0]        d_sync_r;

    state_t            state_r;
    logic [9:0]        col_r;
    logic [9:0]        line_r;
    logic [ADDR_W-1:0] addr_r;
    logic              phase_r;
    logic              any_r;
    logic [7:0]        hi_r;

    logic [15:0]       pix_data_r;
    logic              pix_valid_r;
    logic [9:0]        pix_col_r;
    logic [ADDR_W-1:0] pix_addr_r;
    logic              frame_done_r;
    logic              line_err_r;

    logic              vsync_rise_s;
    logic              vsync_fall_s;
    logic              href_s;
    logic              href_rise_s;
    logic              href_fall_s;
    logic              pclk_rise_s;
    logic              phase_eff_s;
    logic [9:0]        col_eff_s;
    logic              in_range_s;

    // Two-flop synchronizers plus a delay stage on the control lines for edge detection
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ctl_meta_r <= 3'b000;
            ctl_sync_r <= 3'b000;
            ctl_dly_r  <= 3'b000;
            d_meta_r   <= 8'h00;
            d_sync_r   <= 8'h00;
        end else begin
            ctl_meta_r <= {VSYNC, HREF, PCLK};
            ctl_sync_r <= ctl_meta_r;
            ctl_dly_r  <= ctl_sync_r;
            d_meta_r   <= D;
            d_sync_r   <= d_meta_r;
        end
    end

    // Edge strobes; a line start in the same cycle as a byte forces that byte to phase 0 / column 0
    always_comb begin
        vsync_rise_s = ctl_sync_r[2] & ~ctl_dly_r[2];
        vsync_fall_s = ~ctl_sync_r[2] & ctl_dly_r[2];
        href_s       = ctl_sync_r[1];
        href_rise_s  = ctl_sync_r[1] & ~ctl_dly_r[1];
        href_fall_s  = ~ctl_sync_r[1] & ctl_dly_r[1];
        pclk_rise_s  = ctl_sync_r[0] & ~ctl_dly_r[0];
        col_eff_s    = href_rise_s ? 10'd0 : col_r;
        phase_eff_s  = href_rise_s ? 1'b0 : phase_r;
        in_range_s   = (col_eff_s < H_LIM) && (line_r < V_LIM);
    end

    // Capture FSM with counters and registered pixel/status outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r      <= ST_IDLE;
            col_r        <= 10'd0;
            line_r       <= 10'd0;
            addr_r       <= '0;
            phase_r      <= 1'b0;
            any_r        <= 1'b0;
            hi_r         <= 8'h00;
            pix_data_r   <= 16'h0000;
            pix_valid_r  <= 1'b0;
            pix_col_r    <= 10'd0;
            pix_addr_r   <= '0;
            frame_done_r <= 1'b0;
            line_err_r   <= 1'b0;
        end else begin
            pix_valid_r  <= 1'b0;
            frame_done_r <= 1'b0;
            line_err_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (START) begin
                        state_r <= ST_WAIT_VS;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT_VS: begin
                    if (!START) begin
                        state_r <= ST_IDLE;
                    end else if (vsync_fall_s) begin
                        state_r <= ST_CAPTURE;
                        col_r   <= 10'd0;
                        line_r  <= 10'd0;
                        addr_r  <= '0;
                        phase_r <= 1'b0;
                        any_r   <= 1'b0;
                    end else begin
                        state_r <= ST_WAIT_VS;
                    end
                end
                ST_CAPTURE: begin
                    if (vsync_rise_s) begin
                        frame_done_r <= any_r;
                        state_r      <= START ? ST_WAIT_VS : ST_IDLE;
                    end else begin
                        if (href_fall_s) begin
                            if (line_r < V_LIM) begin
                                line_r <= line_r + 10'd1;
                            end
                            // An odd byte count leaves a half pixel behind; drop it and flag the line
                            line_err_r <= phase_r;
                            phase_r    <= 1'b0;
                        end else if (href_rise_s) begin
                            col_r   <= 10'd0;
                            phase_r <= 1'b0;
                        end
                        if (href_s && pclk_rise_s) begin
                            if (!phase_eff_s) begin
                                hi_r    <= d_sync_r;
                                phase_r <= 1'b1;
                            end else begin
                                phase_r <= 1'b0;
                                if (in_range_s) begin
                                    pix_data_r  <= {hi_r, d_sync_r};
                                    pix_valid_r <= 1'b1;
                                    pix_col_r   <= col_eff_s;
                                    pix_addr_r  <= addr_r;
                                    col_r       <= col_eff_s + 10'd1;
                                    addr_r      <= addr_r + ADDR_ONE;
                                    any_r       <= 1'b1;
                                end
                            end
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign PIXEL_DATA  = pix_data_r;
    assign PIXEL_VALID = pix_valid_r;
    assign PIXEL_COL   = pix_col_r;
    assign PIXEL_ADDR  = pix_addr_r;
    assign FRAME_DONE  = frame_done_r;
    assign LINE_ERR    = line_err_r;

endmodule

// File: tb/tb_pixel_capture.sv
// Directed bench for pixel_capture: a full-size instance and a 4x2 instance share one camera stream,
// each checked cycle by cycle against a frame-level model of expected strobes and pulses.
module tb_pixel_capture;

    localparam int HA = 640;
    localparam int VA = 480;
    localparam int HB = 4;
    localparam int VB = 2;
    localparam int AW = 19;
    localparam int LAT = 3;  // two synchronizer flops plus the registered output

    logic          CLK = 1'b0;
    logic          RST_N, START, VSYNC, HREF, PCLK;
    logic [7:0]    D;
    logic [15:0]   data_a, data_b;
    logic          valid_a, valid_b, fd_a, fd_b, le_a, le_b;
    logic [9:0]    col_a, col_b;
    logic [AW-1:0] addr_a, addr_b;

    pixel_capture #(.H_PIXELS(HA), .V_PIXELS(VA), .ADDR_W(AW)) dut_a (
        .CLK(CLK), .RST_N(RST_N), .START(START), .VSYNC(VSYNC), .HREF(HREF), .PCLK(PCLK), .D(D),
        .PIXEL_DATA(data_a), .PIXEL_VALID(valid_a), .PIXEL_COL(col_a), .PIXEL_ADDR(addr_a),
        .FRAME_DONE(fd_a), .LINE_ERR(le_a));

    pixel_capture #(.H_PIXELS(HB), .V_PIXELS(VB), .ADDR_W(AW)) dut_b (
        .CLK(CLK), .RST_N(RST_N), .START(START), .VSYNC(VSYNC), .HREF(HREF), .PCLK(PCLK), .D(D),
        .PIXEL_DATA(data_b), .PIXEL_VALID(valid_b), .PIXEL_COL(col_b), .PIXEL_ADDR(addr_b),
        .FRAME_DONE(fd_b), .LINE_ERR(le_b));

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0]   data;
        logic [9:0]    col;
        logic [AW-1:0] addr;
        int            cyc;
    } pix_t;

    pix_t qpa[$];
    pix_t qpb[$];
    int   qfa[$];
    int   qfb[$];
    int   qea[$];
    int   qeb[$];

    int            m_cap[2], m_phase[2], m_col[2], m_line[2], m_addr[2], m_any[2], m_h[2], m_v[2];
    logic [7:0]    m_hi[2];
    logic [15:0]   last_data[2];
    logic [9:0]    last_col[2];
    logic [AW-1:0] last_addr[2];
    int            n_pix[2], n_fd[2], n_le[2];
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    int            s0, s1, f0, f1, l0;
    logic [7:0]    lbuf [0:1399];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    task automatic m_vs_fall();
        for (int k = 0; k < 2; k++) begin
            if (m_cap[k] == 0 && START == 1'b1) begin
                m_cap[k] = 1; m_col[k] = 0; m_line[k] = 0; m_addr[k] = 0; m_phase[k] = 0; m_any[k] = 0;
            end
        end
    endtask

    task automatic m_vs_rise();
        for (int k = 0; k < 2; k++) begin
            if (m_cap[k] != 0) begin
                if (m_any[k] != 0) begin
                    if (k == 0) qfa.push_back(cyc + LAT); else qfb.push_back(cyc + LAT);
                end
                m_cap[k] = 0;
            end
        end
    endtask

    task automatic m_href_rise();
        for (int k = 0; k < 2; k++) begin
            m_col[k] = 0; m_phase[k] = 0;
        end
    endtask

    task automatic m_href_fall();
        for (int k = 0; k < 2; k++) begin
            if (m_cap[k] != 0) begin
                if (m_line[k] < m_v[k]) m_line[k]++;
                if (m_phase[k] != 0) begin
                    if (k == 0) qea.push_back(cyc + LAT); else qeb.push_back(cyc + LAT);
                end
                m_phase[k] = 0;
            end
        end
    endtask

    task automatic m_byte(input logic [7:0] b);
        pix_t e;
        for (int k = 0; k < 2; k++) begin
            if (m_cap[k] != 0) begin
                if (m_phase[k] == 0) begin
                    m_hi[k] = b; m_phase[k] = 1;
                end else begin
                    m_phase[k] = 0;
                    if (m_col[k] < m_h[k] && m_line[k] < m_v[k]) begin
                        e.data = {m_hi[k], b}; e.col = 10'(m_col[k]); e.addr = AW'(m_addr[k]); e.cyc = cyc + LAT;
                        if (k == 0) qpa.push_back(e); else qpb.push_back(e);
                        m_col[k]++; m_addr[k]++; m_any[k] = 1;
                    end
                end
            end
        end
    endtask

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            m_cap[k] = 0; m_phase[k] = 0; m_col[k] = 0; m_line[k] = 0; m_addr[k] = 0; m_any[k] = 0;
            last_data[k] = 16'h0000; last_col[k] = 10'd0; last_addr[k] = '0;
        end
        qpa.delete(); qpb.delete(); qfa.delete(); qfb.delete(); qea.delete(); qeb.delete();
    endtask

    // ---------------- compare process ----------------
    task automatic check_dut(input int k, input logic v, input logic [15:0] dat, input logic [9:0] col,
                             input logic [AW-1:0] adr, input logic fd, input logic le);
        pix_t e;
        int   have, t;
        have = (k == 0) ? qpa.size() : qpb.size();
        if (v) begin
            n_pix[k]++;
            chk("strobe_expected", (have > 0) ? 32'd1 : 32'd0, 32'd1);
            if (have > 0) begin
                if (k == 0) e = qpa.pop_front(); else e = qpb.pop_front();
                chk("strobe_cycle", cyc, e.cyc);
                chk("pixel_data", dat, e.data);
                chk("pixel_col", col, e.col);
                chk("pixel_addr", adr, e.addr);
                last_data[k] = e.data; last_col[k] = e.col; last_addr[k] = e.addr;
            end
        end else begin
            if (have > 0) begin
                if (k == 0) e = qpa[0]; else e = qpb[0];
                if (e.cyc < cyc) begin
                    chk("strobe_missing", cyc, e.cyc);
                    if (k == 0) void'(qpa.pop_front()); else void'(qpb.pop_front());
                end
            end
            chk("hold_data", dat, last_data[k]);
            chk("hold_col", col, last_col[k]);
            chk("hold_addr", adr, last_addr[k]);
        end
        have = (k == 0) ? qfa.size() : qfb.size();
        if (fd) begin
            n_fd[k]++;
            chk("frame_done_expected", (have > 0) ? 32'd1 : 32'd0, 32'd1);
            if (have > 0) begin
                if (k == 0) t = qfa.pop_front(); else t = qfb.pop_front();
                chk("frame_done_cycle", cyc, t);
            end
        end else if (have > 0) begin
            t = (k == 0) ? qfa[0] : qfb[0];
            if (t < cyc) begin
                chk("frame_done_missing", cyc, t);
                if (k == 0) void'(qfa.pop_front()); else void'(qfb.pop_front());
            end
        end
        have = (k == 0) ? qea.size() : qeb.size();
        if (le) begin
            n_le[k]++;
            chk("line_err_expected", (have > 0) ? 32'd1 : 32'd0, 32'd1);
            if (have > 0) begin
                if (k == 0) t = qea.pop_front(); else t = qeb.pop_front();
                chk("line_err_cycle", cyc, t);
            end
        end else if (have > 0) begin
            t = (k == 0) ? qea[0] : qeb[0];
            if (t < cyc) begin
                chk("line_err_missing", cyc, t);
                if (k == 0) void'(qea.pop_front()); else void'(qeb.pop_front());
            end
        end
    endtask

    always @(negedge CLK) begin
        if (RST_N === 1'b1) begin
            check_dut(0, valid_a, data_a, col_a, addr_a, fd_a, le_a);
            check_dut(1, valid_b, data_b, col_b, addr_b, fd_b, le_b);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic vs_fall();
        @(negedge CLK); VSYNC = 1'b0; m_vs_fall(); tick(8);
    endtask

    task automatic vs_rise();
        @(negedge CLK); VSYNC = 1'b1; m_vs_rise(); tick(8);
    endtask

    // PCLK period is 4 CLK, D changes while PCLK is low
    task automatic send_line(input int n, input bit same_edge, input bit end_line);
        if (!same_edge) begin
            @(negedge CLK); HREF = 1'b1; m_href_rise(); tick(2);
        end
        for (int i = 0; i < n; i++) begin
            @(negedge CLK); PCLK = 1'b0; D = lbuf[i];
            @(negedge CLK);
            @(negedge CLK); PCLK = 1'b1;
            if (i == 0 && same_edge) begin
                HREF = 1'b1; m_href_rise();
            end
            m_byte(lbuf[i]);
            @(negedge CLK);
        end
        if (end_line) begin
            @(negedge CLK); PCLK = 1'b0; tick(1);
            @(negedge CLK); HREF = 1'b0; m_href_fall(); tick(4);
        end
    endtask

    task automatic fill(input int seed, input int mult);
        for (int i = 0; i < 1400; i++) lbuf[i] = 8'((i * mult + seed) & 255);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        m_h[0] = HA; m_h[1] = HB; m_v[0] = VA; m_v[1] = VB;
        for (int k = 0; k < 2; k++) begin
            n_pix[k] = 0; n_fd[k] = 0; n_le[k] = 0; m_hi[k] = 8'h00;
        end
        m_reset();
        RST_N = 1'b0; START = 1'b0; VSYNC = 1'b1; HREF = 1'b0; PCLK = 1'b0; D = 8'h00;
        tick(3);
        chk("reset_valid", valid_a, 32'd0);
        chk("reset_data", data_a, 32'd0);
        chk("reset_addr", addr_b, 32'd0);
        chk("reset_frame_done", fd_a, 32'd0);
        @(negedge CLK); RST_N = 1'b1; tick(4);

        // START low across a whole frame: nothing captured
        fill(3, 17);
        vs_fall(); send_line(8, 1'b0, 1'b1); vs_rise();
        chk("idle_no_strobe", n_pix[0], 32'd0);

        // Frame 1: two RGB565 pixels, odd-length line, line starting on the same edge as a byte
        START = 1'b1; tick(4);
        vs_fall();
        lbuf[0] = 8'hF8; lbuf[1] = 8'h00; lbuf[2] = 8'h07; lbuf[3] = 8'hE0;
        send_line(4, 1'b0, 1'b1);
        chk("rgb_count", n_pix[0], 32'd2);
        chk("rgb_data", data_a, 32'h07E0);
        chk("rgb_col", col_a, 32'd1);
        chk("rgb_addr", addr_a, 32'd1);
        lbuf[0] = 8'h11; lbuf[1] = 8'h22; lbuf[2] = 8'h33; lbuf[3] = 8'h44; lbuf[4] = 8'h55;
        send_line(5, 1'b0, 1'b1);
        chk("odd_count", n_pix[0], 32'd4);
        chk("odd_line_err", n_le[0], 32'd1);
        lbuf[0] = 8'h66; lbuf[1] = 8'h77; lbuf[2] = 8'h88; lbuf[3] = 8'h99;
        send_line(4, 1'b1, 1'b1);
        chk("same_edge_data", data_a, 32'h8899);
        chk("same_edge_col", col_a, 32'd1);
        chk("same_edge_addr", addr_a, 32'd5);
        vs_rise();
        chk("frame1_done_a", n_fd[0], 32'd1);
        chk("frame1_done_b", n_fd[1], 32'd1);

        // Frame 2: 4x2 instance fills exactly, extra line discarded there
        s1 = n_pix[1]; f1 = n_fd[1]; s0 = n_pix[0];
        fill(3, 17);
        vs_fall();
        send_line(8, 1'b0, 1'b1); send_line(8, 1'b0, 1'b1); send_line(4, 1'b0, 1'b1);
        vs_rise();
        chk("small_count", n_pix[1] - s1, 32'd8);
        chk("small_last_addr", addr_b, 32'd7);
        chk("small_frame_done", n_fd[1] - f1, 32'd1);
        chk("full_count", n_pix[0] - s0, 32'd10);

        // Frame 3: 700-pixel line truncated at H_PIXELS
        s0 = n_pix[0]; s1 = n_pix[1];
        fill(1, 5);
        vs_fall(); send_line(1400, 1'b0, 1'b1);
        chk("long_count", n_pix[0] - s0, 32'd640);
        chk("long_last_col", col_a, 32'd639);
        chk("long_small_count", n_pix[1] - s1, 32'd4);
        vs_rise();

        // Frame 4: START dropped mid-frame, frame still completes, then capture stays off
        f0 = n_fd[0];
        fill(9, 3);
        vs_fall(); send_line(4, 1'b0, 1'b1);
        START = 1'b0; tick(4);
        send_line(4, 1'b0, 1'b1); vs_rise();
        chk("drop_frame_done", n_fd[0] - f0, 32'd1);
        s0 = n_pix[0]; f0 = n_fd[0];
        vs_fall(); send_line(4, 1'b0, 1'b1); vs_rise();
        chk("after_drop_count", n_pix[0] - s0, 32'd0);
        chk("after_drop_done", n_fd[0] - f0, 32'd0);

        // Reset in the middle of a line
        START = 1'b1; tick(4);
        vs_fall();
        lbuf[0] = 8'h12; lbuf[1] = 8'h34; lbuf[2] = 8'h56;
        send_line(3, 1'b0, 1'b0);
        chk("pre_reset_data", data_a, 32'h1234);
        @(negedge CLK); RST_N = 1'b0;
        #1;
        chk("midrst_data", data_a, 32'd0);
        chk("midrst_col", col_a, 32'd0);
        chk("midrst_addr", addr_a, 32'd0);
        chk("midrst_valid", valid_a, 32'd0);
        HREF = 1'b0; PCLK = 1'b0; m_reset();
        tick(3);
        @(negedge CLK); RST_N = 1'b1; tick(4);
        s0 = n_pix[0];
        fill(7, 11);
        send_line(4, 1'b0, 1'b1);
        chk("post_reset_no_strobe", n_pix[0] - s0, 32'd0);
        vs_rise(); vs_fall();
        lbuf[0] = 8'hF8; lbuf[1] = 8'h00; lbuf[2] = 8'h07; lbuf[3] = 8'hE0;
        send_line(4, 1'b0, 1'b1);
        chk("post_reset_count", n_pix[0] - s0, 32'd2);
        chk("post_reset_addr", addr_a, 32'd1);
        vs_rise();

        tick(10);
        chk("pending_pix_a", qpa.size(), 32'd0);
        chk("pending_pix_b", qpb.size(), 32'd0);
        chk("pending_fd", qfa.size() + qfb.size(), 32'd0);
        chk("pending_le", qea.size() + qeb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
